// File: rtl/sample_pingpong_writer_pkg.sv
// Shared definitions for the ping-pong sample writer: default sample and
// address widths, bank count and the saturating counter helper.
package sample_pingpong_writer_pkg;

    localparam int SPW_B_W_DEF   = 8;
    localparam int SPW_A_W_DEF   = 9;
    localparam int SPW_NUM_BANKS = 2;
    localparam int SPW_OVF_W     = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SPW_OVF_W-1:0] spw_sat_inc(input logic [SPW_OVF_W-1:0] v);
        logic [SPW_OVF_W-1:0] r;
        r = v;
        if (v != {SPW_OVF_W{1'b1}}) begin
            r = v + {{(SPW_OVF_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_pingpong_writer_edge.sv
// Registered 1-bit rising-edge detector with synchronous active-high reset.
// The previous input level is held in a flop; rise_o is high in the cycle
// where the input is 1 and was 0 one cycle earlier.
module rise_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // Remember last cycle's level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/sample_pingpong_writer.sv
// Producer side of the DPRAM ping-pong sample buffers. Writes accepted
// samples into two banks of 2^A_W words, hands each full bank to the
// consumer with a one-cycle cons_start pulse and frees it on the rising
// edge of cons_done. Banks are consumed strictly in fill order.
// Optional feature: define SPW_OVF_COUNT_EN to add the saturating
// 16-bit ovf_count output (dropped-sample counter).
module sample_pingpong_writer
    import sample_pingpong_writer_pkg::*;
#(
    parameter int B_W = SPW_B_W_DEF,
    parameter int A_W = SPW_A_W_DEF
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 enable,
    input  logic                 sample_valid,
    input  logic [B_W-1:0]       sample_data,
    output logic                 sample_ready,
    output logic                 wr_en,
    output logic [A_W:0]         wr_addr,
    output logic [B_W-1:0]       wr_data,
    output logic                 cons_start,
    output logic                 rd_bank,
    input  logic                 cons_done,
    input  logic                 clr_ovf,
`ifdef SPW_OVF_COUNT_EN
    output logic                 overflow,
    output logic [SPW_OVF_W-1:0] ovf_count
`else
    output logic                 overflow
`endif
);

    localparam logic [A_W-1:0] PTR_MAX = {A_W{1'b1}};
    localparam logic [A_W-1:0] PTR_ONE = {{(A_W-1){1'b0}}, 1'b1};

    logic                     wr_bank_q,    wr_bank_d;
    logic [A_W-1:0]           wr_ptr_q,     wr_ptr_d;
    logic [SPW_NUM_BANKS-1:0] bank_full_q,  bank_full_d;
    logic                     rd_bank_q,    rd_bank_d;
    logic                     cons_busy_q,  cons_busy_d;
    logic                     wr_en_q,      wr_en_d;
    logic [A_W:0]             wr_addr_q,    wr_addr_d;
    logic [B_W-1:0]           wr_data_q,    wr_data_d;
    logic                     cons_start_q, cons_start_d;
    logic                     overflow_q,   overflow_d;

    logic done_rise;
    logic accept;
    logic drop;
    logic release_ev;
    logic dispatch;

    rise_edge_det u_done_edge (
        .clk_i  (sys_clk),
        .rst_i  (sys_rst),
        .d_i    (cons_done),
        .rise_o (done_rise)
    );

    // The writer only stalls when the bank it is about to fill is still owned by the consumer.
    assign sample_ready = enable && !bank_full_q[wr_bank_q];
    assign accept       = sample_valid && sample_ready;
    assign drop         = sample_valid && enable && bank_full_q[wr_bank_q];
    assign release_ev   = done_rise && cons_busy_q;
    assign dispatch     = !cons_busy_q && bank_full_q[rd_bank_q] && !cons_start_q;

    // Next-state for write pointer, bank ownership, dispatch handshake and sticky overflow.
    always_comb begin
        wr_bank_d    = wr_bank_q;
        wr_ptr_d     = wr_ptr_q;
        bank_full_d  = bank_full_q;
        rd_bank_d    = rd_bank_q;
        cons_busy_d  = cons_busy_q;
        wr_en_d      = accept;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cons_start_d = 1'b0;
        overflow_d   = overflow_q;

        if (accept) begin
            wr_addr_d = {wr_bank_q, wr_ptr_q};
            wr_data_d = sample_data;
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
            if (wr_ptr_q == PTR_MAX) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
            end
        end

        // Release targets the read bank, a fill always targets the other one,
        // so both updates can land in the same cycle without conflict.
        if (release_ev) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            cons_busy_d            = 1'b0;
        end

        if (dispatch) begin
            cons_start_d = 1'b1;
            cons_busy_d  = 1'b1;
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // State and output registers; reset discards any partially or fully written banks.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_bank_q    <= 1'b0;
            wr_ptr_q     <= '0;
            bank_full_q  <= '0;
            rd_bank_q    <= 1'b0;
            cons_busy_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cons_start_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_bank_q    <= wr_bank_d;
            wr_ptr_q     <= wr_ptr_d;
            bank_full_q  <= bank_full_d;
            rd_bank_q    <= rd_bank_d;
            cons_busy_q  <= cons_busy_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cons_start_q <= cons_start_d;
            overflow_q   <= overflow_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cons_start = cons_start_q;
    assign rd_bank    = rd_bank_q;
    assign overflow   = overflow_q;

`ifdef SPW_OVF_COUNT_EN
    logic [SPW_OVF_W-1:0] ovf_count_q, ovf_count_d;

    // Dropped-sample counter: a drop coinciding with a clear restarts the count at one.
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (drop) begin
            if (clr_ovf) begin
                ovf_count_d = {{(SPW_OVF_W-1){1'b0}}, 1'b1};
            end else begin
                ovf_count_d = spw_sat_inc(ovf_count_q);
            end
        end else if (clr_ovf) begin
            ovf_count_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_sample_pingpong_writer.sv
// Bench for sample_pingpong_writer: two instances (16-word and 512-word banks)
// share one directed stimulus stream; each is checked every cycle against a
// count-based model (samples accepted, banks dispatched, banks released).
module tb_sample_pingpong_writer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       vld;
    logic [7:0] data;
    logic       done;
    logic       clr;

    logic       s_ready, s_wen, s_start, s_rd, s_ovf;
    logic [4:0] s_addr;
    logic [7:0] s_data;
    logic       b_ready, b_wen, b_start, b_rd, b_ovf;
    logic [9:0] b_addr;
    logic [7:0] b_data;
`ifdef SPW_OVF_COUNT_EN
    logic [15:0] s_cnt, b_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sample_pingpong_writer #(.B_W(8), .A_W(4)) dut_s (
        .sys_clk(clk), .sys_rst(rst), .enable(en), .sample_valid(vld), .sample_data(data),
        .sample_ready(s_ready), .wr_en(s_wen), .wr_addr(s_addr), .wr_data(s_data),
        .cons_start(s_start), .rd_bank(s_rd), .cons_done(done), .clr_ovf(clr),
`ifdef SPW_OVF_COUNT_EN
        .overflow(s_ovf), .ovf_count(s_cnt)
`else
        .overflow(s_ovf)
`endif
    );

    sample_pingpong_writer #(.B_W(8), .A_W(9)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .enable(en), .sample_valid(vld), .sample_data(data),
        .sample_ready(b_ready), .wr_en(b_wen), .wr_addr(b_addr), .wr_data(b_data),
        .cons_start(b_start), .rd_bank(b_rd), .cons_done(done), .clr_ovf(clr),
`ifdef SPW_OVF_COUNT_EN
        .overflow(b_ovf), .ovf_count(b_cnt)
`else
        .overflow(b_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: everything follows from three totals.
    typedef struct {
        int t;          // samples accepted since reset
        int rel;        // banks released
        int disp;       // banks dispatched
        bit start;
        bit wen;
        int waddr;
        int wdata;
        bit ovf;
        int cnt;
        bit done_prev;
    } mdl_t;

    function automatic mdl_t mstep(input mdl_t m, input int depth, input bit r, input bit e,
                                   input bit v, input int d, input bit dn, input bit c);
        mdl_t n;
        int   filled;
        int   outst;
        bit   busy;
        bit   drp;
        n      = m;
        filled = m.t / depth;
        outst  = filled - m.rel;
        busy   = m.disp > m.rel;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        n.wen = v && e && (outst < 2);
        if (n.wen) begin
            n.waddr = m.t % (2 * depth);
            n.wdata = d;
            n.t     = m.t + 1;
        end
        drp = v && e && (outst == 2);
        if (drp) n.ovf = 1'b1;
        else if (c) n.ovf = 1'b0;
        if (drp) n.cnt = c ? 1 : ((m.cnt == 65535) ? 65535 : m.cnt + 1);
        else if (c) n.cnt = 0;
        n.start = 1'b0;
        if (!busy && (filled > m.rel) && !m.start) begin
            n.start = 1'b1;
            n.disp  = m.disp + 1;
        end
        if (dn && !m.done_prev && busy) n.rel = m.rel + 1;
        n.done_prev = dn;
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    mdl_t ms = '{default: 0};
    mdl_t mb = '{default: 0};

    // Per-cycle compare, small-bank instance.
    always begin
        @(posedge clk);
        ms = mstep(ms, 16, rst, en, vld, int'(data), done, clr);
        #1;
        chk("s.wr_en", int'(s_wen), int'(ms.wen));
        if (ms.wen) begin
            chk("s.wr_addr", int'(s_addr), ms.waddr);
            chk("s.wr_data", int'(s_data), ms.wdata);
        end
        chk("s.cons_start", int'(s_start), int'(ms.start));
        chk("s.rd_bank", int'(s_rd), ms.rel % 2);
        chk("s.overflow", int'(s_ovf), int'(ms.ovf));
        chk("s.ready", int'(s_ready), int'(en && ((ms.t / 16 - ms.rel) < 2)));
`ifdef SPW_OVF_COUNT_EN
        chk("s.ovf_count", int'(s_cnt), ms.cnt);
`endif
    end

    // Per-cycle compare, large-bank instance.
    always begin
        @(posedge clk);
        mb = mstep(mb, 512, rst, en, vld, int'(data), done, clr);
        #1;
        chk("b.wr_en", int'(b_wen), int'(mb.wen));
        if (mb.wen) begin
            chk("b.wr_addr", int'(b_addr), mb.waddr);
            chk("b.wr_data", int'(b_data), mb.wdata);
        end
        chk("b.cons_start", int'(b_start), int'(mb.start));
        chk("b.rd_bank", int'(b_rd), mb.rel % 2);
        chk("b.overflow", int'(b_ovf), int'(mb.ovf));
        chk("b.ready", int'(b_ready), int'(en && ((mb.t / 512 - mb.rel) < 2)));
`ifdef SPW_OVF_COUNT_EN
        chk("b.ovf_count", int'(b_cnt), mb.cnt);
`endif
    end

    // One clock: inputs set before this are sampled at the edge; return 2 units after it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int starts;

    initial begin
        rst = 1'b1; en = 1'b1; vld = 1'b0; data = 8'h00; done = 1'b0; clr = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("lit.reset_wr_en", int'(s_wen), 0);
        chk("lit.reset_wr_addr", int'(s_addr), 0);
        chk("lit.reset_ready", int'(s_ready), 1);

        // Fill one bank with 0x00..0x0F.
        for (int i = 0; i < 16; i++) begin
            vld = 1'b1; data = 8'(i);
            step();
        end
        vld = 1'b0;
        chk("lit.fill_last_addr", int'(s_addr), 15);
        chk("lit.fill_last_data", int'(s_data), 15);
        chk("lit.fill_start_early", int'(s_start), 0);
        step();
        chk("lit.fill_start", int'(s_start), 1);
        chk("lit.fill_rd_bank", int'(s_rd), 0);
        step();
        chk("lit.fill_start_once", int'(s_start), 0);

        // Ping-pong: release bank 0, then fill bank 1 and rewrite bank 0.
        done = 1'b1; step(); done = 1'b0; step();
        for (int i = 0; i < 32; i++) begin
            vld = 1'b1; data = 8'(8'h20 + i);
            step();
            if (i == 0)  chk("lit.pp_bank1_addr", int'(s_addr), 16);
            if (i == 16) chk("lit.pp_rewrite_addr", int'(s_addr), 0);
        end
        vld = 1'b0;
        step(); step();
        chk("lit.pp_rd_bank1", int'(s_rd), 1);
        chk("lit.pp_both_full", int'(s_ready), 0);
        done = 1'b1; step(); done = 1'b0; step(); step(); step();
        done = 1'b1; step(); done = 1'b0; step(); step();

        // Overflow: consumer never finishes, 8 of 40 samples dropped.
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            vld = 1'b1; data = 8'(i);
            step();
        end
        vld = 1'b0;
        chk("lit.ovf_flag", int'(s_ovf), 1);
        chk("lit.ovf_ready", int'(s_ready), 0);
`ifdef SPW_OVF_COUNT_EN
        chk("lit.ovf_count8", int'(s_cnt), 8);
`endif
        clr = 1'b1; step(); clr = 1'b0;
        chk("lit.ovf_cleared", int'(s_ovf), 0);
        vld = 1'b1; clr = 1'b1; step(); vld = 1'b0; clr = 1'b0;
        chk("lit.ovf_drop_wins", int'(s_ovf), 1);
`ifdef SPW_OVF_COUNT_EN
        chk("lit.ovf_count1", int'(s_cnt), 1);
`endif
        clr = 1'b1; step(); clr = 1'b0; step();

        // Done held high for 50 cycles gives exactly one release.
        starts = 0;
        done = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (s_start) starts++;
        end
        done = 1'b0; step();
        chk("lit.done_level_starts", starts, 1);
        chk("lit.done_level_rd", int'(s_rd), 1);
        done = 1'b1; step(); done = 1'b0; step(); step();
        chk("lit.done_release2_rd", int'(s_rd), 0);
        done = 1'b1; step(); step(); step(); done = 1'b0; step();
        chk("lit.done_idle_rd", int'(s_rd), 0);

        // Gating and reset mid-fill.
        en = 1'b0; vld = 1'b1; data = 8'h55;
        for (int i = 0; i < 5; i++) step();
        chk("lit.gate_ready", int'(s_ready), 0);
        chk("lit.gate_ovf", int'(s_ovf), 0);
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data = 8'(8'h60 + i);
            step();
        end
        rst = 1'b1; data = 8'h99; step(); rst = 1'b0;
        chk("lit.rst_wr_en", int'(s_wen), 0);
        chk("lit.rst_wr_addr", int'(s_addr), 0);
        chk("lit.rst_wr_data", int'(s_data), 0);
        data = 8'h77; step(); vld = 1'b0;
        chk("lit.rst_next_addr", int'(s_addr), 0);
        chk("lit.rst_next_data", int'(s_data), 8'h77);
        step();

        // Long run exercising the 512-word banks.
        rst = 1'b1; step(); rst = 1'b0;
        starts = 0;
        for (int i = 0; i < 1100; i++) begin
            vld = 1'b1; data = 8'(i);
            done = ((i / 20) % 2) == 1;
            step();
            if (b_start) starts++;
            if (i == 511) chk("lit.big_last_addr", int'(b_addr), 511);
            if (i == 512) chk("lit.big_bank1_addr", int'(b_addr), 512);
        end
        vld = 1'b0; done = 1'b0;
        step(); step();
        chk("lit.big_starts", starts, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
